// File: rtl/imem_loader_if.sv
// Stream-in and IMEM write-port signals of the program loader.
// The loader takes the slave side; the byte source / memory observer takes the master side.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: length (2 B, LE), payload, 8-bit checksum.
// Writes payload into IMEM from address 0 and releases cpu_hold only on a valid image.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_LO | expecting length low byte
// LEN_HI | expecting length high byte, length checked here
// DATA   | receiving payload, one IMEM write per byte
// CHK    | expecting checksum byte
// DONE   | image valid, core released
// ERROR  | bad length or checksum, core held
module imem_loader #(
    parameter int IMEM_SIZE = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    imem_loader_if.slave bus,
    output logic       busy,
    output logic       done,
    output logic [1:0] error,
    output logic       cpu_hold
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(IMEM_SIZE);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic [1:0]        error_q, error_d;
    logic              cpu_hold_q, cpu_hold_d;

    logic              in_session;
    logic              xfer;
    logic [7:0]        sum_next;
    logic [15:0]       len_full;
    logic              len_bad;

    assign in_session = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                        (state_q == DATA)   || (state_q == CHK);
    assign xfer       = bus.s_valid && in_session;
    assign sum_next   = sum_q + bus.s_data;
    assign len_full   = {bus.s_data, len_q[7:0]};
    // Image must be non-empty, fit the IMEM, and consist of whole 32-bit words.
    assign len_bad    = (len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN) ||
                        (len_full[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_hold_d  = cpu_hold_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d    = LEN_LO;
                    done_d     = 1'b0;
                    error_d    = 2'd0;
                    cpu_hold_d = 1'b1;
                    idx_d      = 16'd0;
                    sum_d      = 8'd0;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = bus.s_data;
                    sum_d      = sum_next;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d = len_full;
                    sum_d = sum_next;
                    if (len_bad) begin
                        state_d = ERROR;
                        error_d = 2'd1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(idx_q);
                    mem_wdata_d = bus.s_data;
                    idx_d       = idx_q + 16'd1;
                    sum_d       = sum_next;
                    if (idx_q == len_q - 16'd1) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (xfer) begin
                    if (sum_next == 8'd0) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = ERROR;
                        error_d    = 2'd2;
                        cpu_hold_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= 16'd0;
            idx_q       <= 16'd0;
            sum_q       <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 2'd0;
            cpu_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    assign bus.s_ready   = in_session;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = in_session;
    assign done          = done_q;
    assign error         = error_q;
    assign cpu_hold      = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader; expected writes and status come from
// a frame model (length rules, byte sum) rather than from the loader's internals.
module tb_imem_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic [1:0] error;
    logic       cpu_hold;

    imem_loader_if #(.ADDR_W(32)) ifc ();

    imem_loader #(.IMEM_SIZE(1024), .ADDR_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (ifc.slave),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    int          wq_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifc.mem_we === 1'b1) begin
            wq_addr.push_back(ifc.mem_addr);
            wq_data.push_back(ifc.mem_wdata);
            wq_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        n_vec++; if (ifc.s_ready !== 1'b0) begin n_err++; $display("FAIL %s s_ready: got %b exp 0", name, ifc.s_ready); end
        n_vec++; if (ifc.mem_we !== 1'b0) begin n_err++; $display("FAIL %s mem_we: got %b exp 0", name, ifc.mem_we); end
        n_vec++; if (ifc.mem_addr !== 32'd0) begin n_err++; $display("FAIL %s mem_addr: got %0h exp 0", name, ifc.mem_addr); end
        n_vec++; if (ifc.mem_wdata !== 8'd0) begin n_err++; $display("FAIL %s mem_wdata: got %0h exp 0", name, ifc.mem_wdata); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy: got %b exp 0", name, busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL %s done: got %b exp 0", name, done); end
        n_vec++; if (error !== 2'd0) begin n_err++; $display("FAIL %s error: got %0d exp 0", name, error); end
        n_vec++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL %s cpu_hold: got %b exp 1", name, cpu_hold); end
    endtask

    // Presents one byte at a negedge and returns at the negedge after it was taken.
    task automatic send_byte(input logic [7:0] b, input bit with_start, input string name);
        int w = 0;
        ifc.s_valid = 1'b1;
        ifc.s_data  = b;
        if (with_start) start = 1'b1;
        while (ifc.s_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            start = 1'b0;
            w++;
        end
        if (w >= 20) begin
            n_vec++; n_err++;
            $display("FAIL %s handshake: got s_ready=0 for 20 cycles exp 1", name);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic void make_frame(input int len, input bit corrupt, output logic [7:0] f[$]);
        logic [7:0] s;
        f.delete();
        f.push_back(len[7:0]);
        f.push_back(len[15:8]);
        for (int i = 0; i < len; i++) f.push_back(8'($urandom_range(0, 255)));
        s = 8'd0;
        foreach (f[i]) s = s + f[i];
        f.push_back(8'(8'd0 - s) + (corrupt ? 8'd1 : 8'd0));
    endfunction

    task automatic run_frame(input logic [7:0] frm[$], input bit gaps, input int start_at,
                             input string name);
        int len, n, sum, exp_err, exp_writes;
        bit bad;
        len = int'({frm[1], frm[0]});
        bad = (len == 0) || (len > 1024) || (len % 4 != 0);
        n   = bad ? 2 : len + 3;
        sum = 0;
        for (int i = 0; i < n; i++) sum = (sum + int'(frm[i])) % 256;
        exp_err    = bad ? 1 : ((sum == 0) ? 0 : 2);
        exp_writes = bad ? 0 : len;

        clear_writes();
        pulse_start();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_after_start: got %b exp 1", name, busy); end
        n_vec++; if (done !== 1'b0 || error !== 2'd0 || cpu_hold !== 1'b1) begin
            n_err++; $display("FAIL %s start_clear: got done=%b err=%0d hold=%b exp 0/0/1", name, done, error, cpu_hold);
        end
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    ifc.s_valid = 1'b0;
                    ifc.s_data  = 8'($urandom_range(0, 255));
                    @(negedge clk);
                end
            end
            send_byte(frm[i], i == start_at, name);
        end
        // A byte offered after the session ends must not be consumed.
        ifc.s_valid = 1'b1;
        ifc.s_data  = 8'($urandom_range(0, 255));
        n_vec++; if (ifc.s_ready !== 1'b0) begin n_err++; $display("FAIL %s s_ready_after: got %b exp 0", name, ifc.s_ready); end
        @(negedge clk);
        @(negedge clk);
        ifc.s_valid = 1'b0;

        n_vec++; if (wq_addr.size() != exp_writes) begin
            n_err++; $display("FAIL %s write_count: got %0d exp %0d", name, wq_addr.size(), exp_writes);
        end
        for (int i = 0; i < exp_writes && i < wq_addr.size(); i++) begin
            n_vec++; if (wq_addr[i] !== 32'(i) || wq_data[i] !== frm[2+i]) begin
                n_err++; $display("FAIL %s write[%0d]: got addr=%0h data=%0h exp addr=%0h data=%0h",
                                  name, i, wq_addr[i], wq_data[i], i, frm[2+i]);
            end
            if (!gaps && i > 0) begin
                n_vec++; if (wq_cyc[i] != wq_cyc[i-1] + 1) begin
                    n_err++; $display("FAIL %s back_to_back[%0d]: got gap %0d exp 1", name, i, wq_cyc[i] - wq_cyc[i-1]);
                end
            end
        end
        n_vec++; if (error !== 2'(exp_err)) begin n_err++; $display("FAIL %s error: got %0d exp %0d", name, error, exp_err); end
        n_vec++; if (done !== (exp_err == 0)) begin n_err++; $display("FAIL %s done: got %b exp %b", name, done, exp_err == 0); end
        n_vec++; if (cpu_hold !== (exp_err != 0)) begin n_err++; $display("FAIL %s cpu_hold: got %b exp %b", name, cpu_hold, exp_err != 0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_end: got %b exp 0", name, busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ifc.s_valid = 1'b0; ifc.s_data = 8'd0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (ifc.s_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b exp 0", ifc.s_ready); end
    endtask

    task automatic test_known_image();
        logic [7:0] f[$];
        // Payload bytes sum with the length byte to 0xFF, so 0x01 is the closing checksum.
        f = '{8'h08, 8'h00, 8'h93, 8'h00, 8'h40, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h01};
        run_frame(f, 1'b0, -1, "known_good");
        f[10] = 8'h5D;
        run_frame(f, 1'b0, -1, "known_chk5d");
        f[10] = 8'h5E;
        run_frame(f, 1'b0, -1, "known_chk5e");
    endtask

    task automatic test_bad_length();
        logic [7:0] f[$];
        f = '{8'h06, 8'h00, 8'h11, 8'h22};
        run_frame(f, 1'b0, -1, "len6");
        f = '{8'h00, 8'h00, 8'h11, 8'h22};
        run_frame(f, 1'b0, -1, "len0");
        f = '{8'h04, 8'h04, 8'h11, 8'h22};
        run_frame(f, 1'b0, -1, "len1028");
    endtask

    task automatic test_max_len();
        logic [7:0] f[$];
        make_frame(1024, 1'b0, f);
        run_frame(f, 1'b0, -1, "len1024");
    endtask

    task automatic test_random_valid();
        logic [7:0] f[$];
        for (int it = 0; it < 6; it++) begin
            make_frame(4 * $urandom_range(1, 16), ($urandom_range(0, 3) == 0), f);
            run_frame(f, 1'b1, -1, $sformatf("rand%0d", it));
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] f[$];
        make_frame(8, 1'b0, f);
        clear_writes();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(f[i], 1'b0, "mid_reset");
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        ifc.s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        make_frame(12, 1'b0, f);
        run_frame(f, 1'b0, -1, "after_reset");
    endtask

    task automatic test_start_in_data();
        logic [7:0] f[$];
        make_frame(16, 1'b0, f);
        run_frame(f, 1'b0, 5, "start_in_data");
        pulse_start();
        n_vec++; if (done !== 1'b0 || busy !== 1'b1 || ifc.s_ready !== 1'b1) begin
            n_err++; $display("FAIL restart: got done=%b busy=%b ready=%b exp 0/1/1", done, busy, ifc.s_ready);
        end
        make_frame(4, 1'b0, f);
        run_frame(f, 1'b0, -1, "restart_frame");
    endtask

    initial begin
        test_reset();
        test_known_image();
        test_bad_length();
        test_max_len();
        test_random_valid();
        test_reset_mid();
        test_start_in_data();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
